dram_read_fetch: RTL

- Avalon-MM read master that streams a contiguous block of 32-bit words out of DRAM and into the accelerator datapath.
- Sits directly upstream of the DeltaAcc compute core, between the DRAM controller master port and the core's operand input.
- Software or the core's control logic programs a base address and word count, then pulses start.
- Words are buffered in a small FIFO and presented on a valid/ready stream.

---
 rtl/dram_read_fetch.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/dram_read_fetch.sv
// Avalon-MM read master: fetches a contiguous block of 32-bit words from DRAM into a small output FIFO.
// Latency: a word accepted from DRAM shows on out_valid one cycle later (read data registered into the FIFO).
// Backpressure: Read is only raised with a free FIFO slot (counting this cycle's pop); full + out_ready=0 halts reads.
//
// Ports:
//   clock, reset                  - single clock, asynchronous active-low reset
//   start, base_addr, word_count  - fetch request (start honoured only while idle)
//   busy, done                    - status; done is a one-cycle pulse after the last word leaves the FIFO
//   DRAM_master_*                 - Avalon-MM read master towards the DRAM controller
//   out_valid, out_data, out_ready- output word stream (FIFO head)
//   checksum                      - present only with DRAM_FETCH_CHECKSUM_EN: mod-2^32 sum of words pushed
//                                   since the last accepted start
module dram_read_fetch #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    input  logic             DRAM_master_WaitRequest,
    output logic             DRAM_master_Read,
    output logic [31:0]      DRAM_master_Address,
    output logic [3:0]       DRAM_master_ByteEnable,
    input  logic [31:0]      DRAM_master_ReadData,
    output logic             out_valid,
    output logic [31:0]      out_data,
    input  logic             out_ready
`ifdef DRAM_FETCH_CHECKSUM_EN
    ,
    output logic [31:0]      checksum
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] L_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [31:0]      r_addr;
    logic [CNT_W-1:0] r_rem;
    logic             r_hold;      // a read was stalled last cycle and must be re-presented unchanged

    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [31:0]      r_last;      // last popped word, shown while the FIFO is empty

    logic             w_start_acc;
    logic             w_pop;
    logic             w_space;
    logic             w_read;
    logic             w_accept;
    logic             w_push;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign out_valid   = (r_count != '0);
    assign w_pop       = out_valid && out_ready;
    assign w_space     = (r_count != L_FULL) || w_pop;

    // Once a read has been presented and stalled, it stays up regardless of FIFO
    // occupancy: the slot it reserved cannot be taken because nothing else pushes.
    assign w_read   = (r_state == S_READ) && (r_rem != '0) && (r_hold || w_space);
    assign w_accept = w_read && !DRAM_master_WaitRequest;
    assign w_push   = w_accept;

    assign DRAM_master_Read       = w_read;
    assign DRAM_master_Address    = r_addr;
    assign DRAM_master_ByteEnable = 4'b1111;

    assign out_data = out_valid ? r_mem[r_rd_ptr] : r_last;

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. The zero-count decision is taken from the latched count
    // one cycle after start, so the wide compare sits behind a register.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                if (r_rem == '0) begin
                    w_next = S_DONE;
                end else if (w_accept && (r_rem == CNT_W'(1))) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_count == '0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Address / remaining-count / stall tracking
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_addr <= '0;
            r_rem  <= '0;
            r_hold <= 1'b0;
        end else begin
            r_hold <= w_read && DRAM_master_WaitRequest;
            if (w_start_acc) begin
                r_addr <= base_addr & 32'hFFFF_FFFC;
                r_rem  <= word_count;
            end else if (w_accept) begin
                r_addr <= r_addr + 32'd4;        // wraps silently past 0xFFFFFFFC
                r_rem  <= r_rem - CNT_W'(1);
            end
        end
    end

    // FIFO storage: contents need no reset, the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= DRAM_master_ReadData;
        end
    end

    // FIFO pointers, occupancy and held output word
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef DRAM_FETCH_CHECKSUM_EN
    logic [31:0] r_sum;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sum <= '0;
        end else if (w_start_acc) begin
            r_sum <= '0;
        end else if (w_push) begin
            r_sum <= r_sum + DRAM_master_ReadData;
        end
    end

    assign checksum = r_sum;
`endif

endmodule
